// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV32I hazard/forwarding controller.
// Optional build macro HAZARD_PERF_CNT_EN (see hazard_fwd_ctrl.sv) enables the stall/flush counters.
package hazard_pkg;

    // Forwarding mux select for SrcA/SrcB in the execute stage.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Controller state: running normally or frozen waiting for a D-cache refill.
    typedef enum logic {
        RUN       = 1'b0,
        MISS_WAIT = 1'b1
    } hz_state_t;

    // ResultSrc encoding that identifies a load in the execute stage.
    localparam logic [1:0] LOAD_RESULTSRC = 2'b01;

    // True when the execute-stage instruction takes its result from memory.
    function automatic logic is_load(input logic [1:0] result_src);
        return (result_src == LOAD_RESULTSRC);
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// With HAZARD_PERF_CNT_EN defined the bundle also carries the 32-bit performance counters.
interface hazard_fwd_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] Rs1D;
    logic [REG_AW-1:0] Rs2D;
    logic [REG_AW-1:0] Rs1E;
    logic [REG_AW-1:0] Rs2E;
    logic [REG_AW-1:0] RdE;
    logic              RegWriteE;
    logic [1:0]        ResultSrcE;
    logic              PCSrcE;
    logic              CacheMissM;
    logic              CacheReadyM;

    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;
    logic              StallF;
    logic              StallD;
    logic              StallE;
    logic              StallM;
    logic              StallW;
    logic              FlushD;
    logic              FlushE;
    logic              MissTimeout;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]       LoadStallCnt;
    logic [31:0]       MissStallCnt;
    logic [31:0]       FlushCnt;

    // Pipeline side: supplies register indices and events, consumes controls.
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, PCSrcE, CacheMissM, CacheReadyM,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
        input  MissTimeout, LoadStallCnt, MissStallCnt, FlushCnt
    );

    // Controller side.
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, PCSrcE, CacheMissM, CacheReadyM,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
        output MissTimeout, LoadStallCnt, MissStallCnt, FlushCnt
    );
`else
    // Pipeline side: supplies register indices and events, consumes controls.
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, PCSrcE, CacheMissM, CacheReadyM,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
        input  MissTimeout
    );

    // Controller side.
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, PCSrcE, CacheMissM, CacheReadyM,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
        output MissTimeout
    );
`endif

endinterface

// File: rtl/hazard_dst_pipe.sv
// Shadow copy of the destination register / write-enable of the M and W stages,
// so forwarding decisions do not depend on the datapath's own pipeline registers.
module hazard_dst_pipe #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_m,
    input  logic              flush_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              reg_write_e,
    output logic [REG_AW-1:0] rd_m,
    output logic              reg_write_m,
    output logic [REG_AW-1:0] rd_w,
    output logic              reg_write_w
);

    logic [REG_AW-1:0] rd_m_r;
    logic [REG_AW-1:0] rd_w_r;
    logic              reg_write_m_r;
    logic              reg_write_w_r;

    // Advance E->M->W unless memory is stalled; a flushed E instruction enters M as a non-writer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_m_r        <= {REG_AW{1'b0}};
            rd_w_r        <= {REG_AW{1'b0}};
            reg_write_m_r <= 1'b0;
            reg_write_w_r <= 1'b0;
        end else if (!stall_m) begin
            rd_m_r        <= rd_e;
            reg_write_m_r <= reg_write_e & ~flush_e;
            rd_w_r        <= rd_m_r;
            reg_write_w_r <= reg_write_m_r;
        end else begin
            rd_m_r        <= rd_m_r;
            reg_write_m_r <= reg_write_m_r;
            rd_w_r        <= rd_w_r;
            reg_write_w_r <= reg_write_w_r;
        end
    end

    assign rd_m        = rd_m_r;
    assign reg_write_m = reg_write_m_r;
    assign rd_w        = rd_w_r;
    assign reg_write_w = reg_write_w_r;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard / forwarding controller for the 5-stage RV32I pipeline: forwarding selects,
// load-use stall, branch flush and a full freeze while a D-cache miss is outstanding.
// Optional build macro HAZARD_PERF_CNT_EN adds LoadStallCnt/MissStallCnt/FlushCnt.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int         REG_AW       = 5,
    parameter logic [7:0] MISS_TIMEOUT = 8'd255
) (
    input logic             clk,
    input logic             rst,
    hazard_fwd_ctrl_if.slave hz
);

    hz_state_t         state_r;
    hz_state_t         state_nxt_s;
    logic [7:0]        miss_cnt_r;
    logic              timeout_r;

    logic [REG_AW-1:0] rd_m_s;
    logic [REG_AW-1:0] rd_w_s;
    logic              reg_write_m_s;
    logic              reg_write_w_s;

    logic              lw_stall_s;
    logic              freeze_s;
    fwd_sel_t          fwd_a_s;
    fwd_sel_t          fwd_b_s;
    logic              stall_fd_s;
    logic              stall_emw_s;
    logic              flush_d_s;
    logic              flush_e_s;

    // Newest producer wins: M-stage result before writeback, x0 never forwarded.
    function automatic fwd_sel_t fwd_pick(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic              we_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_w
    );
        fwd_sel_t sel;
        if (we_m && (rd_m != {REG_AW{1'b0}}) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (we_w && (rd_w != {REG_AW{1'b0}}) && (rd_w == rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    hazard_dst_pipe #(
        .REG_AW (REG_AW)
    ) u_dst_pipe (
        .clk         (clk),
        .rst         (rst),
        .stall_m     (stall_emw_s),
        .flush_e     (flush_e_s),
        .rd_e        (hz.RdE),
        .reg_write_e (hz.RegWriteE),
        .rd_m        (rd_m_s),
        .reg_write_m (reg_write_m_s),
        .rd_w        (rd_w_s),
        .reg_write_w (reg_write_w_s)
    );

    // Miss FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Miss FSM next state: enter on a miss, leave on the refill-ready cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN: begin
                if (hz.CacheMissM) begin
                    state_nxt_s = MISS_WAIT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            MISS_WAIT: begin
                if (hz.CacheReadyM) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = MISS_WAIT;
                end
            end
            default: state_nxt_s = RUN;
        endcase
    end

    // Saturating count of waiting cycles; cleared whenever the controller returns to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cnt_r <= 8'd0;
        end else if (state_nxt_s == RUN) begin
            miss_cnt_r <= 8'd0;
        end else if ((state_r == MISS_WAIT) && (miss_cnt_r != 8'hFF)) begin
            miss_cnt_r <= miss_cnt_r + 8'd1;
        end else begin
            miss_cnt_r <= miss_cnt_r;
        end
    end

    // Sticky timeout flag: once the wait hits the limit it stays set until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_r <= 1'b0;
        end else if ((state_r == MISS_WAIT) && (miss_cnt_r == MISS_TIMEOUT)) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    // Load-use detection and freeze condition (freeze applies in the miss cycle itself).
    always_comb begin
        lw_stall_s = is_load(hz.ResultSrcE) && hz.RegWriteE && (hz.RdE != {REG_AW{1'b0}}) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
        freeze_s   = ((state_r == RUN) && hz.CacheMissM) || (state_r == MISS_WAIT);
    end

    // Stage controls and forwarding selects; freeze overrides load-use and branch handling.
    always_comb begin
        fwd_a_s     = FWD_RF;
        fwd_b_s     = FWD_RF;
        stall_fd_s  = 1'b0;
        stall_emw_s = 1'b0;
        flush_d_s   = 1'b0;
        flush_e_s   = 1'b0;
        if (rst) begin
            fwd_a_s = FWD_RF;
        end else begin
            fwd_a_s = fwd_pick(hz.Rs1E, rd_m_s, reg_write_m_s, rd_w_s, reg_write_w_s);
            fwd_b_s = fwd_pick(hz.Rs2E, rd_m_s, reg_write_m_s, rd_w_s, reg_write_w_s);
            if (freeze_s) begin
                stall_fd_s  = 1'b1;
                stall_emw_s = 1'b1;
            end else begin
                stall_fd_s  = lw_stall_s & ~hz.PCSrcE;
                flush_d_s   = hz.PCSrcE;
                flush_e_s   = lw_stall_s | hz.PCSrcE;
            end
        end
    end

    assign hz.ForwardAE   = fwd_a_s;
    assign hz.ForwardBE   = fwd_b_s;
    assign hz.StallF      = stall_fd_s;
    assign hz.StallD      = stall_fd_s;
    assign hz.StallE      = stall_emw_s;
    assign hz.StallM      = stall_emw_s;
    assign hz.StallW      = stall_emw_s;
    assign hz.FlushD      = flush_d_s;
    assign hz.FlushE      = flush_e_s;
    assign hz.MissTimeout = timeout_r & ~rst;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] load_stall_cnt_r;
    logic [31:0] miss_stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_stall_cnt_r <= 32'd0;
            miss_stall_cnt_r <= 32'd0;
            flush_cnt_r      <= 32'd0;
        end else begin
            load_stall_cnt_r <= load_stall_cnt_r + {31'd0, (lw_stall_s & ~freeze_s)};
            miss_stall_cnt_r <= miss_stall_cnt_r + {31'd0, freeze_s};
            flush_cnt_r      <= flush_cnt_r + {31'd0, (hz.PCSrcE & ~freeze_s)};
        end
    end

    assign hz.LoadStallCnt = load_stall_cnt_r;
    assign hz.MissStallCnt = miss_stall_cnt_r;
    assign hz.FlushCnt     = flush_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl: directed scenarios followed by random traffic,
// expected controls computed by a behavioural model and checked by a separate monitor.
module tb_hazard_fwd_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hazard_fwd_ctrl_if #(.REG_AW(5)) hz ();

    hazard_fwd_ctrl #(
        .REG_AW       (5),
        .MISS_TIMEOUT (8'd255)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    typedef struct {
        bit         rst;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        bit         we;
        logic [1:0] rsrc;
        bit         pc, miss, ready;
    } stim_t;

    typedef struct {
        logic [1:0]  fa, fb;
        bit          sf, sd, se, sm, sw, fd, fe, to;
        bit          lw, frz;
        logic [31:0] lc, mc, fc;
    } exp_t;

    typedef struct {
        logic [4:0] rd;
        bit         we;
    } wr_t;

    // Reference model state: writers in flight (index 0 = M, 1 = W), miss bookkeeping.
    wr_t         inflight[$];
    bit          in_miss;
    int          waited;
    bit          timeout;
    logic [31:0] lcnt, mcnt, fcnt;
    exp_t        cur_exp;
    exp_t        sb[$];

    int tests = 0;
    int fails = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 1'b0, rs1d: 5'd0, rs2d: 5'd0, rs1e: 5'd0, rs2e: 5'd0, rde: 5'd0,
              we: 1'b0, rsrc: 2'b00, pc: 1'b0, miss: 1'b0, ready: 1'b0};
        return s;
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
        for (int k = 0; k < 2; k++) begin
            if (inflight[k].we && inflight[k].rd != 5'd0 && inflight[k].rd == rs)
                return (k == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    // Expected controls for the inputs currently on the bus.
    function automatic exp_t model_eval();
        exp_t e;
        e = '{fa: 2'b00, fb: 2'b00, sf: 0, sd: 0, se: 0, sm: 0, sw: 0, fd: 0, fe: 0, to: 0,
              lw: 0, frz: 0, lc: lcnt, mc: mcnt, fc: fcnt};
        if (!rst) begin
            e.lw  = (hz.ResultSrcE == 2'b01) && hz.RegWriteE && hz.RdE != 5'd0 &&
                    (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
            e.frz = in_miss || hz.CacheMissM;
            e.fa  = model_fwd(hz.Rs1E);
            e.fb  = model_fwd(hz.Rs2E);
            e.to  = timeout;
            if (e.frz) begin
                {e.sf, e.sd, e.se, e.sm, e.sw} = 5'b11111;
            end else begin
                e.sf = e.lw && !hz.PCSrcE;
                e.sd = e.sf;
                e.fd = hz.PCSrcE;
                e.fe = e.lw || hz.PCSrcE;
            end
        end
        return e;
    endfunction

    // Model state advance at a clock edge, from the inputs that were sampled there.
    task automatic model_clock();
        wr_t n;
        if (rst) begin
            inflight.delete();
            n = '{rd: 5'd0, we: 1'b0};
            inflight.push_back(n);
            inflight.push_back(n);
            in_miss = 0; waited = 0; timeout = 0;
            lcnt = 32'd0; mcnt = 32'd0; fcnt = 32'd0;
        end else begin
            if (!cur_exp.sm) begin
                n = '{rd: hz.RdE, we: hz.RegWriteE && !cur_exp.fe};
                inflight.push_front(n);
                void'(inflight.pop_back());
            end
            if (cur_exp.lw && !cur_exp.frz) lcnt = lcnt + 32'd1;
            if (cur_exp.frz)                mcnt = mcnt + 32'd1;
            if (hz.PCSrcE && !cur_exp.frz)  fcnt = fcnt + 32'd1;
            if (in_miss) begin
                if (waited >= 255) timeout = 1;
                if (hz.CacheReadyM) begin
                    in_miss = 0;
                    waited  = 0;
                end else if (waited < 255) begin
                    waited++;
                end
            end else if (hz.CacheMissM) begin
                in_miss = 1;
            end
        end
    endtask

    task automatic apply(input stim_t s);
        @(posedge clk);
        #1;
        model_clock();
        rst            = s.rst;
        hz.Rs1D        = s.rs1d;
        hz.Rs2D        = s.rs2d;
        hz.Rs1E        = s.rs1e;
        hz.Rs2E        = s.rs2e;
        hz.RdE         = s.rde;
        hz.RegWriteE   = s.we;
        hz.ResultSrcE  = s.rsrc;
        hz.PCSrcE      = s.pc;
        hz.CacheMissM  = s.miss;
        hz.CacheReadyM = s.ready;
        cur_exp = model_eval();
        sb.push_back(cur_exp);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    // Monitor: compare every presented cycle against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ForwardAE",   32'(hz.ForwardAE),   32'(e.fa));
                chk("ForwardBE",   32'(hz.ForwardBE),   32'(e.fb));
                chk("StallF",      32'(hz.StallF),      32'(e.sf));
                chk("StallD",      32'(hz.StallD),      32'(e.sd));
                chk("StallE",      32'(hz.StallE),      32'(e.se));
                chk("StallM",      32'(hz.StallM),      32'(e.sm));
                chk("StallW",      32'(hz.StallW),      32'(e.sw));
                chk("FlushD",      32'(hz.FlushD),      32'(e.fd));
                chk("FlushE",      32'(hz.FlushE),      32'(e.fe));
                chk("MissTimeout", 32'(hz.MissTimeout), 32'(e.to));
`ifdef HAZARD_PERF_CNT_EN
                chk("LoadStallCnt", hz.LoadStallCnt, e.lc);
                chk("MissStallCnt", hz.MissStallCnt, e.mc);
                chk("FlushCnt",     hz.FlushCnt,     e.fc);
`endif
            end
        end
    end

    initial begin
        stim_t s;
        hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0; hz.RdE = 5'd0;
        hz.RegWriteE = 1'b0; hz.ResultSrcE = 2'b00; hz.PCSrcE = 1'b0;
        hz.CacheMissM = 1'b0; hz.CacheReadyM = 1'b0;
        cur_exp = '{fa: 2'b00, fb: 2'b00, sf: 0, sd: 0, se: 0, sm: 0, sw: 0, fd: 0, fe: 0, to: 0,
                    lw: 0, frz: 0, lc: 32'd0, mc: 32'd0, fc: 32'd0};

        // Reset, then idle with reset released.
        s = idle(); s.rst = 1'b1;
        repeat (3) apply(s);
        apply(idle());

        // ALU producer r5 -> forwarded from M, then from W.
        s = idle(); s.rde = 5'd5; s.we = 1'b1; apply(s);
        s = idle(); s.rs1e = 5'd5; apply(s);
        s = idle(); s.rs2e = 5'd5; apply(s);

        // r7 in both M and W: M must win. Then r0 writer is never forwarded.
        s = idle(); s.rde = 5'd7; s.we = 1'b1; apply(s); apply(s);
        s = idle(); s.rs1e = 5'd7; apply(s);
        s = idle(); s.we = 1'b1; apply(s);
        s = idle(); s.rs1e = 5'd0; s.rs2e = 5'd0; apply(s);

        // Load-use on r3: one stall/bubble cycle, then dependent consumer in E.
        s = idle(); s.rde = 5'd3; s.we = 1'b1; s.rsrc = 2'b01; s.rs2d = 5'd3; apply(s);
        s = idle(); s.rs2d = 5'd3; apply(s);
        s = idle(); s.rs2e = 5'd3; apply(s);
        apply(idle());

        // Miss held four cycles with a writer parked in E, ready on the fifth.
        s = idle(); s.rde = 5'd9; s.we = 1'b1; apply(s);
        s = idle(); s.rde = 5'd4; s.we = 1'b1; s.rs1e = 5'd9; s.miss = 1'b1;
        repeat (4) apply(s);
        s.ready = 1'b1; apply(s);
        s = idle(); s.rs1e = 5'd4; s.rs2e = 5'd9; apply(s);

        // Branch during a miss: no flush while frozen, flush on resume.
        s = idle(); s.pc = 1'b1; s.miss = 1'b1; repeat (3) apply(s);
        s.ready = 1'b1; apply(s);
        s = idle(); s.pc = 1'b1; apply(s);
        apply(idle());

        // Reset in the middle of a miss.
        s = idle(); s.miss = 1'b1; repeat (3) apply(s);
        s.rst = 1'b1; apply(s);
        apply(idle());

        // Long miss: sticky timeout, survives resume, cleared only by reset.
        s = idle(); s.miss = 1'b1; repeat (300) apply(s);
        s.ready = 1'b1; apply(s);
        repeat (5) apply(idle());
        s = idle(); s.rst = 1'b1; apply(s);
        repeat (2) apply(idle());

        // Random traffic with small register range to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            s.rst   = ($urandom_range(0, 199) == 0);
            s.rs1d  = 5'($urandom_range(0, 7));
            s.rs2d  = 5'($urandom_range(0, 7));
            s.rs1e  = 5'($urandom_range(0, 7));
            s.rs2e  = 5'($urandom_range(0, 7));
            s.rde   = 5'($urandom_range(0, 7));
            s.we    = ($urandom_range(0, 3) != 0);
            s.rsrc  = 2'($urandom_range(0, 3));
            s.pc    = ($urandom_range(0, 7) == 0);
            s.miss  = ($urandom_range(0, 19) == 0);
            s.ready = ($urandom_range(0, 4) == 0);
            apply(s);
        end

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
